// File: rtl/cic_decimator.sv
// cic_decimator
//   Three-stage CIC decimator (R = 3, differential delay 1) with a
//   round-half-up / saturating output stage and a pass-through bypass mode.
//   The decimated stream feeds the downstream notch stage.
//
// Ports
//   clk        system clock (18 MHz)
//   rst_n      asynchronous active-low reset
//   in_valid   qualifies x_in in the current cycle
//   x_in       signed input sample, DATA_WIDTH bits
//   bypass     1 = pass x_in/in_valid straight through with one cycle latency
//   x_out      signed decimated sample, held between strobes
//   out_valid  one-cycle strobe qualifying x_out
module cic_decimator #(
  parameter int DATA_WIDTH = 16
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  input  logic signed [DATA_WIDTH-1:0] x_in,
  input  logic                         bypass,
  output logic signed [DATA_WIDTH-1:0] x_out,
  output logic                         out_valid
);

  // Bit growth of a 3rd-order CIC with R*M = 3 is ceil(3*log2(3)) = 5 bits.
  localparam int ACC_WIDTH = DATA_WIDTH + 5;

  localparam logic signed [ACC_WIDTH:0] SAT_MAX = (ACC_WIDTH+1)'((2 ** (DATA_WIDTH-1)) - 1);
  localparam logic signed [ACC_WIDTH:0] SAT_MIN = -SAT_MAX - (ACC_WIDTH+1)'(1);

  // Divide by 32 with round-half-up, then clamp to the output range.
  // One guard bit keeps the +16 from wrapping near the top of the range.
  function automatic logic signed [DATA_WIDTH-1:0] round_sat(
    input logic signed [ACC_WIDTH-1:0] v
  );
    logic signed [ACC_WIDTH:0] r;
    logic signed [ACC_WIDTH:0] s;
    r = {v[ACC_WIDTH-1], v} + (ACC_WIDTH+1)'(16);
    s = r >>> 5;
    if (s > SAT_MAX) begin
      s = SAT_MAX;
    end else if (s < SAT_MIN) begin
      s = SAT_MIN;
    end
    return DATA_WIDTH'(s);
  endfunction

  logic [1:0]                  phase;
  logic                        comb_en;
  logic signed [ACC_WIDTH-1:0] int1, int2, int3;
  logic signed [ACC_WIDTH-1:0] d1, d2, d3;
  logic signed [ACC_WIDTH-1:0] c1, c2, c3;
  logic signed [ACC_WIDTH-1:0] x_ext;
  logic                        accept;

  assign x_ext  = {{(ACC_WIDTH-DATA_WIDTH){x_in[DATA_WIDTH-1]}}, x_in};
  assign accept = in_valid && !bypass;

  // Comb section reads int3 before this cycle's integrator update.
  always_comb begin
    c1 = int3 - d1;
    c2 = c1 - d2;
    c3 = c2 - d3;
  end

  // ---- stage 0: sample acceptance, phase tracking, decimation event ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase   <= 2'd0;
      comb_en <= 1'b0;
    end else if (bypass) begin
      phase   <= 2'd0;
      comb_en <= 1'b0;
    end else begin
      comb_en <= accept && (phase == 2'd2);
      if (accept) begin
        phase <= (phase == 2'd2) ? 2'd0 : phase + 2'd1;
      end
    end
  end

  // ---- stage 0: integrators (wrap modulo 2^ACC_WIDTH) ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      int1 <= '0;
      int2 <= '0;
      int3 <= '0;
    end else if (bypass) begin
      int1 <= '0;
      int2 <= '0;
      int3 <= '0;
    end else if (accept) begin
      int1 <= int1 + x_ext;
      int2 <= int2 + int1;
      int3 <= int3 + int2;
    end
  end

  // ---- stage 1: comb delays and output register ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      d1        <= '0;
      d2        <= '0;
      d3        <= '0;
      x_out     <= '0;
      out_valid <= 1'b0;
    end else if (bypass) begin
      // A comb_en pending in this cycle is deliberately dropped here.
      d1        <= '0;
      d2        <= '0;
      d3        <= '0;
      x_out     <= x_in;
      out_valid <= in_valid;
    end else begin
      out_valid <= comb_en;
      if (comb_en) begin
        d1    <= int3;
        d2    <= c1;
        d3    <= c2;
        x_out <= round_sat(c3);
      end
    end
  end

endmodule

// File: tb/tb_cic_decimator.sv
// tb_cic_decimator
//   Bench for cic_decimator. The reference model treats the decimator as
//   an FIR over the accepted-sample history: each output is the weighted
//   sum of the most recent accepted samples (weights 1,3,6,7,6,3,1, the
//   impulse response of a 3-stage, R=3 CIC sampled every 3rd input),
//   followed by round-half-up divide by 32 and saturation.
module tb_cic_decimator;
  localparam int DW = 16;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b1;
  logic                 in_valid = 1'b0;
  logic                 bypass = 1'b0;
  logic signed [DW-1:0] x_in = '0;
  logic signed [DW-1:0] x_out;
  logic                 out_valid;

  cic_decimator #(.DATA_WIDTH(DW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .x_in      (x_in),
    .bypass    (bypass),
    .x_out     (x_out),
    .out_valid (out_valid)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Model state
  int hist [9];
  int w    [9] = '{0, 0, 1, 3, 6, 7, 6, 3, 1};
  int acc_cnt;
  int exp_x;
  int exp_v;
  int ov_cnt;

  typedef struct {
    bit v;
    bit upd;
    int x;
  } slot_t;
  slot_t s1, s2;

  typedef struct {
    int x;
    bit gaps;
    int expect_x;
  } dc_row_t;
  dc_row_t rows [9];

  task automatic check(input string name, input logic signed [31:0] act,
                       input logic signed [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  function automatic int ref_out();
    int y;
    y = 0;
    for (int m = 0; m < 9; m++) y += w[m] * hist[m];
    y = (y + 16) >>> 5;
    if (y > 32767) y = 32767;
    if (y < -32768) y = -32768;
    return y;
  endfunction

  task automatic clear_model();
    for (int m = 0; m < 9; m++) hist[m] = 0;
    acc_cnt = 0;
  endtask

  // Drive one cycle of inputs, advance the model, compare after the edge.
  task automatic step(input bit v, input int x, input bit b);
    in_valid = v;
    x_in     = DW'(x);
    bypass   = b;
    s1 = s2;
    s2 = '{default: 0};
    if (b) begin
      s1.v = v;
      s1.upd = 1'b1;
      s1.x = x;
      clear_model();
    end else if (v) begin
      for (int m = 8; m > 0; m--) hist[m] = hist[m-1];
      hist[0] = x;
      acc_cnt++;
      if (acc_cnt == 3) begin
        acc_cnt = 0;
        s2.v = 1'b1;
        s2.upd = 1'b1;
        s2.x = ref_out();
      end
    end
    @(posedge clk);
    #1;
    if (s1.upd) exp_x = s1.x;
    exp_v = int'(s1.v);
    check("out_valid", out_valid, exp_v);
    check("x_out", x_out, exp_x);
    if (out_valid === 1'b1) ov_cnt++;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    in_valid = 1'b0;
    bypass = 1'b0;
    #1;
    check("reset_x_out", x_out, 0);
    check("reset_out_valid", out_valid, 0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    clear_model();
    s1 = '{default: 0};
    s2 = '{default: 0};
    exp_x = 0;
    exp_v = 0;
    ov_cnt = 0;
  endtask

  function automatic int rnd_sample();
    return int'($urandom_range(0, 65535)) - 32768;
  endfunction

  initial begin
    rows[0] = '{1000,   1'b0,    844};
    rows[1] = '{32767,  1'b0,  27647};
    rows[2] = '{-32768, 1'b0, -27648};
    rows[3] = '{1000,   1'b1,    844};
    rows[4] = '{0,      1'b0,      0};
    rows[5] = '{-1000,  1'b0,   -844};
    rows[6] = '{1,      1'b0,      1};
    rows[7] = '{-1,     1'b1,     -1};
    rows[8] = '{16,     1'b0,     14};
    clear_model();
    s1 = '{default: 0};
    s2 = '{default: 0};
    exp_x = 0;
    exp_v = 0;
    ov_cnt = 0;

    #2;
    do_reset();

    // Latency: out_valid appears on the second edge after the 3rd accepted sample.
    step(1, 1000, 0);
    step(1, 1000, 0);
    step(1, 1000, 0);
    check("latency_edge1_valid", out_valid, 0);
    step(0, 0, 0);
    check("latency_edge2_valid", out_valid, 1);
    check("first_output", x_out, 31);
    step(0, 0, 0);
    check("strobe_one_cycle", out_valid, 0);

    // Table-driven DC settling, contiguous and alternate-cycle input.
    foreach (rows[i]) begin
      do_reset();
      for (int k = 0; k < 24; k++) begin
        if (rows[i].gaps) step(0, rnd_sample(), 0);
        step(1, rows[i].x, 0);
      end
      step(0, 0, 0);
      step(0, 0, 0);
      check("dc_settled", x_out, rows[i].expect_x);
      check("dc_out_count", ov_cnt, 8);
    end

    // Long full-scale runs: integrators wrap many times.
    do_reset();
    for (int k = 0; k < 3000; k++) step(1, 32767, 0);
    check("long_pos_settled", x_out, 27647);
    for (int k = 0; k < 3000; k++) step(1, -32768, 0);
    check("long_neg_settled", x_out, -27648);

    // Bypass pass-through, then restart from phase 0.
    step(1, -5, 1);
    check("bypass_x_out", x_out, -5);
    check("bypass_valid", out_valid, 1);
    step(0, 77, 1);
    check("bypass_invalid", out_valid, 0);
    ov_cnt = 0;
    step(1, 1000, 0);
    step(1, 1000, 0);
    step(0, 0, 0);
    step(0, 0, 0);
    check("post_bypass_no_early_out", ov_cnt, 0);
    step(1, 1000, 0);
    step(0, 0, 0);
    check("post_bypass_3rd_sample_out", out_valid, 1);

    // Pending comb_en discarded when bypass rises.
    do_reset();
    step(1, 500, 0);
    step(1, 500, 0);
    step(1, 500, 0);
    step(0, 123, 1);
    check("bypass_drops_pending_valid", out_valid, 0);
    check("bypass_drops_pending_x", x_out, 123);
    step(0, 0, 0);
    check("bypass_no_late_strobe", out_valid, 0);

    // Reset after two accepted samples discards the partial group.
    do_reset();
    for (int k = 0; k < 9; k++) step(1, -2000, 0);
    step(1, 1000, 0);
    step(1, 1000, 0);
    do_reset();
    for (int k = 0; k < 15; k++) step(1, 1000, 0);
    step(0, 0, 0);
    step(0, 0, 0);
    check("post_reset_settled", x_out, 844);
    check("post_reset_out_count", ov_cnt, 5);

    // Long idle mid-stream: no strobes, output held, phase kept.
    do_reset();
    for (int k = 0; k < 7; k++) step(1, rnd_sample(), 0);
    step(0, 0, 0);
    step(0, 0, 0);
    ov_cnt = 0;
    for (int k = 0; k < 50; k++) step(0, rnd_sample(), 0);
    check("idle_no_strobe", ov_cnt, 0);
    step(1, rnd_sample(), 0);
    step(1, rnd_sample(), 0);
    step(0, 0, 0);
    check("idle_resume_phase", ov_cnt, 1);

    // Randomized traffic with occasional bypass bursts.
    do_reset();
    for (int k = 0; k < 4000; k++) begin
      step($urandom_range(0, 9) < 7, rnd_sample(), $urandom_range(0, 63) == 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
